// File: rtl/cks_pkg.sv
// cks_pkg: shared FSM states, key/code constants and decode helpers for coin_key_sync.
package cks_pkg;
    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;
    localparam logic [4:0] KEY_ITEM0 = 5'd16;
    localparam logic [4:0] KEY_ITEM1 = 5'd17;
    localparam logic [4:0] KEY_COIN0 = 5'd18;
    localparam logic [4:0] KEY_COIN1 = 5'd19;
    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_0    = 2'b01;
    localparam logic [1:0] CODE_1    = 2'b10;
    function automatic logic [4:0] hi_idx(input logic [19:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 20; i++) if (v[i]) r = 5'(i);
        return r;
    endfunction
    function automatic logic [1:0] coin_of(input logic [4:0] k);
        return k == KEY_COIN0 ? CODE_0 : k == KEY_COIN1 ? CODE_1 : CODE_NONE;
    endfunction
    function automatic logic [1:0] item_of(input logic [4:0] k);
        return k == KEY_ITEM0 ? CODE_0 : k == KEY_ITEM1 ? CODE_1 : CODE_NONE;
    endfunction
endpackage

// File: rtl/cks_sync2.sv
// cks_sync2: two-flop synchronizer, W bits wide, synchronous active-high reset.
module cks_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] m;
    always_ff @(posedge clk) begin
        if (rst) begin
            m <= '0;
            q <= '0;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/coin_key_sync.sv
// coin_key_sync: debounced 20-key scanner with coin/item decode and valid/ack handshake.
// Define CKS_AUTOREPEAT_EN to re-accept a held key after REPEAT_DELAY, then every REPEAT_PERIOD.
module coin_key_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] pb,
    input  logic        ack,
    output logic        valid,
    output logic        strobe,
    output logic [4:0]  key,
    output logic [1:0]  coin,
    output logic [1:0]  item,
    output logic        overrun
);
    import cks_pkg::*;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE_CYCLES);
    logic [19:0] s;
    logic [4:0] code, cand, cand_n;
    logic anykey, acc, rep_hit;
    logic [CW-1:0] cnt, cnt_n;
    state_t state, nxt;
    cks_sync2 #(.W(20)) u_sync (.clk(clk), .rst(rst), .d(pb), .q(s));
    assign code = hi_idx(s);
    assign anykey = |s;
`ifdef CKS_AUTOREPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [RW-1:0] rcnt;
    logic rep;
    assign rep_hit = state == HELD && anykey && rcnt == (rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
    // Any cycle outside HELD rearms the timer so it counts from the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            rep  <= 1'b0;
        end else if (state != HELD || rep_hit) begin
            rcnt <= RW'(1);
            rep  <= state == HELD;
        end else if (rcnt != '1) begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    localparam int unused_repeat = REPEAT_DELAY + REPEAT_PERIOD;
    assign rep_hit = 1'b0;
`endif
    always_comb begin
        nxt    = state;
        cnt_n  = cnt;
        cand_n = cand;
        acc    = 1'b0;
        case (state)
            IDLE: if (anykey) begin
                nxt    = ARM;
                cnt_n  = CW'(1);
                cand_n = code;
            end
            ARM: if (!anykey) nxt = IDLE;
            else if (code != cand) begin
                cand_n = code;
                cnt_n  = CW'(1);
            end else if (cnt == DB) begin
                acc = 1'b1;
                nxt = HELD;
            end else cnt_n = cnt + 1'b1;
            HELD: if (!anykey) begin
                nxt   = REL;
                cnt_n = CW'(1);
            end else acc = rep_hit;
            REL: if (anykey) nxt = HELD;
            else if (cnt == DB) nxt = IDLE;
            else cnt_n = cnt + 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cand    <= '0;
            valid   <= 1'b0;
            strobe  <= 1'b0;
            key     <= '0;
            coin    <= '0;
            item    <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_n;
            cand   <= cand_n;
            strobe <= acc;
            if (acc && (!valid || ack)) begin
                valid <= 1'b1;
                key   <= cand;
                coin  <= coin_of(cand);
                item  <= item_of(cand);
            end else if (ack) valid <= 1'b0;
            if (acc && valid && !ack) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_coin_key_sync.sv
// tb_coin_key_sync: directed checks of debounce timing, decode, handshake, overrun and reset.
module tb_coin_key_sync;
    logic clk = 1'b0;
    logic rst, ack, valid, strobe, overrun;
    logic [19:0] pb;
    logic [4:0] key;
    logic [1:0] coin, item;
    int checks = 0;
    int fails = 0;
    int ns = 0;
    coin_key_sync dut (
        .clk(clk), .rst(rst), .pb(pb), .ack(ack), .valid(valid), .strobe(strobe),
        .key(key), .coin(coin), .item(item), .overrun(overrun)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ns += int'(strobe);
        end
    endtask
    task automatic bit_on(input int b);
        pb = 20'(1) << b;
    endtask
    initial begin
        rst = 1'b1;
        pb  = '0;
        ack = 1'b0;
        step(2);
        check("rst_valid", valid, 0);
        check("rst_strobe", strobe, 0);
        check("rst_key", key, 0);
        check("rst_coin", coin, 0);
        check("rst_item", item, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        step(1);
        // clean press of key 18: strobe on the 7th edge after driving pb
        ns = 0;
        bit_on(18);
        step(6);
        check("t1_early", ns, 0);
        step(1);
        check("t1_strobe", strobe, 1);
        check("t1_valid", valid, 1);
        check("t1_key", key, 18);
        check("t1_coin", coin, 1);
        check("t1_item", item, 0);
        step(1);
        check("t1_strobe_drop", strobe, 0);
        step(12);
        check("t1_one_event", ns, 1);
        check("t1_valid_hold", valid, 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("t1_ack_clear", valid, 0);
        pb = '0;
        step(10);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("ack_idle_ignored", valid, 0);
        // bounce 1-0-1-0 then hold key 17
        ns = 0;
        bit_on(17); step(1);
        pb = '0;    step(1);
        bit_on(17); step(1);
        pb = '0;    step(1);
        bit_on(17);
        step(6);
        check("t2_no_bounce_strobe", ns, 0);
        step(1);
        check("t2_strobe", strobe, 1);
        check("t2_key", key, 17);
        check("t2_item", item, 2);
        check("t2_coin", coin, 0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        pb = '0;
        step(10);
        // key 19 joins key 16 mid-ARM: debounce restarts on the new code
        ns = 0;
        bit_on(16);
        step(4);
        pb[19] = 1'b1;
        step(6);
        check("t3_restart", ns, 0);
        step(1);
        check("t3_strobe", strobe, 1);
        check("t3_key", key, 19);
        check("t3_coin", coin, 2);
        check("t3_item", item, 0);
        pb = '0;
        step(10);
        // accept with ack in the same cycle replaces the pending event
        bit_on(18);
        step(6);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("t4a_strobe", strobe, 1);
        check("t4a_valid", valid, 1);
        check("t4a_key", key, 18);
        check("t4a_coin", coin, 1);
        check("t4a_no_overrun", overrun, 0);
        pb = '0;
        step(10);
        // accept while pending and no ack drops the event
        bit_on(16);
        step(7);
        check("t4b_strobe", strobe, 1);
        check("t4b_key_kept", key, 18);
        check("t4b_item_kept", item, 0);
        check("t4b_overrun", overrun, 1);
        check("t4b_valid", valid, 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        pb = '0;
        step(10);
        check("t4b_sticky", overrun, 1);
        // reset in ARM discards the press; held key is re-debounced
        bit_on(17);
        step(4);
        rst = 1'b1;
        step(1);
        check("t5_rst_valid", valid, 0);
        check("t5_rst_strobe", strobe, 0);
        check("t5_rst_key", key, 0);
        check("t5_rst_overrun", overrun, 0);
        rst = 1'b0;
        ns = 0;
        step(6);
        check("t5_early", ns, 0);
        step(1);
        check("t5_strobe", strobe, 1);
        check("t5_key", key, 17);
        check("t5_item", item, 2);
        step(20);
        check("t5_single_event", ns, 1);
        pb = '0;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(10);
`ifdef CKS_AUTOREPEAT_EN
        begin
            int t[8];
            int n = 0;
            int exp_off[6] = '{0, 50, 60, 70, 80, 90};
            bit_on(16);
            for (int i = 0; i < 100; i++) begin
                step(1);
                if (strobe && n < 8) begin
                    t[n] = i;
                    n++;
                end
                ack = strobe;
            end
            pb = '0;
            step(10);
            ack = 1'b0;
            check("ar_count", n, 6);
            for (int k = 1; k < 6; k++) if (k < n) check("ar_offset", t[k] - t[0], exp_off[k]);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/coin_key_sync.md
COIN_KEY_SYNC -- requirements
Module: coin_key_sync

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a press or a release.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50: cycles held before the first auto-repeat (used only with CKS_AUTOREPEAT_EN).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10: cycles between later auto-repeats (used only with CKS_AUTOREPEAT_EN).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port pb, input, 20: raw asynchronous pushbuttons [19:0].
REQ-007 SHALL have port ack, input, 1: consumer has taken the pending event.
REQ-008 SHALL have port valid, output, 1: an event is pending.
REQ-009 SHALL have port strobe, output, 1: one-cycle pulse when an event is accepted.
REQ-010 SHALL have port key, output, 5: index of the accepted key.
REQ-011 SHALL have port coin, output, 2: coin code of the pending event.
REQ-012 SHALL have port item, output, 2: item code of the pending event.
REQ-013 SHALL have port overrun, output, 1: sticky flag, set when an event is dropped.

Function
REQ-014 SHALL pass pb through a two-flop synchronizer; all later logic uses only the synchronized value.
REQ-015 SHALL form code, the index of the highest-numbered set synchronized bit; anykey SHALL be the OR of all synchronized bits.
REQ-016 SHALL implement FSM IDLE, ARM, HELD, REL.
- IDLE: anykey -> ARM, counter=1, cand=code.
- ARM: !anykey -> IDLE; code!=cand -> cand=code, counter=1; counter==DEBOUNCE_CYCLES -> accept, go HELD; otherwise counter+1.
- HELD: !anykey -> REL, counter=1.
- REL: anykey -> HELD; counter==DEBOUNCE_CYCLES -> IDLE; otherwise counter+1.
REQ-017 Accept SHALL occur on the cycle after the synchronized key has been stable for DEBOUNCE_CYCLES cycles, that is, DEBOUNCE_CYCLES+2 cycles after a clean pb edge.
REQ-018 On accept, strobe SHALL be 1 for exactly that cycle; key, coin and item SHALL load on the same edge that sets valid.
REQ-019 The coin and item codes SHALL be decoded from the accepted key.
- key 18 -> coin=01; key 19 -> coin=10; otherwise coin=00.
- key 16 -> item=01; key 17 -> item=10; otherwise item=00.
REQ-020 valid SHALL stay 1 until a cycle with ack=1; valid SHALL clear on the next edge.
- ack while valid=0 SHALL be ignored.
REQ-021 Accept with ack in the same cycle SHALL load the new event and leave valid=1, with no overrun.
REQ-022 Accept while valid=1 and ack=0 SHALL drop the new event: the held outputs are unchanged and overrun is set; strobe still pulses.
REQ-023 Counters SHALL saturate and never wrap; a key held indefinitely SHALL produce exactly one event (without CKS_AUTOREPEAT_EN).

Reset
REQ-024 rst=1 on a clock edge SHALL force: synchronizer flops=0, FSM=IDLE, counters=0, valid=0, strobe=0, key=0, coin=0, item=0, overrun=0.
REQ-025 Reset mid-debounce or mid-hold SHALL discard the press; a key still held after reset SHALL be re-debounced from IDLE.
REQ-026 overrun SHALL clear only on rst.

Configuration
REQ-027 With CKS_AUTOREPEAT_EN defined, HELD SHALL re-accept the same key REPEAT_DELAY cycles after the first accept, then every REPEAT_PERIOD cycles while still held; each re-accept follows REQ-018 to REQ-022.
REQ-028 Without CKS_AUTOREPEAT_EN, the REPEAT parameters SHALL be unused and no repeat logic SHALL be synthesized.

Structure
REQ-029 Package cks_pkg SHALL hold: the FSM state enum; key constants KEY_ITEM0=16, KEY_ITEM1=17, KEY_COIN0=18, KEY_COIN1=19; and the 2-bit coin/item code constants.
REQ-030 The synchronizer SHALL be sub-module cks_sync2, parameterized by width.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Clean press of pb[18] held 20 cycles -> one strobe 6 cycles after the edge; key=18, coin=01, item=00, valid=1 until ack.
REQ-032 pb[17] bounces 1-0-1-0 at 1-cycle spacing, then stays high -> no strobe during the bounce; one event with key=17, item=10.
REQ-033 pb[16] held, pb[19] added mid-ARM -> counter restarts; event key=19, coin=10.
REQ-034 Event pending with ack=0, then a second press of pb[18] -> strobe pulses, outputs keep the first key, overrun=1; ack on the same cycle as an accept -> valid stays 1 with the new key.
REQ-035 rst asserted in ARM -> all outputs 0 next edge; key still held -> one event 6 cycles after rst drops.
REQ-036 With CKS_AUTOREPEAT_EN, REPEAT_DELAY=50, REPEAT_PERIOD=10, ack pulsed on every strobe, pb[16] held 100 cycles -> strobes at accept, +50, +60, +70, +80, +90.
